mem_ctrl: RTL

Byte-serial memory controller and arbiter sharing one 8-bit synchronous RAM port between instruction fetch (IF, read-only) and the MEM stage (loads and stores). It sequences 1/2/4-byte little-endian accesses into single-byte RAM cycles and sign- or zero-extends load results. It reuses the busy/ready handshake already presented to the MEM stage, and sits between the pipeline stages and the top-level RAM pins.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl_ext.sv | 21 ++
 rtl/mem_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states,
// access lengths, request owners and the length normaliser.
package mem_ctrl_pkg;

    localparam int RAM_ADDR_W_DEF = 17;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_READ  = 2'd1,
        STATE_WRITE = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_e;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    // Anything that is not a byte or half access becomes a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            LEN_BYTE: return LEN_BYTE;
            LEN_HALF: return LEN_HALF;
            default:  return LEN_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// Load-result extender: sign- or zero-extends the low byte/half of an
// assembled little-endian word; full words pass through untouched.
module mem_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  length,
    input  logic        is_signed,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (length)
            LEN_BYTE: ext = {{24{is_signed & raw[7]}}, raw[7:0]};
            LEN_HALF: ext = {{16{is_signed & raw[15]}}, raw[15:0]};
            default:  ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM requests onto a single 8-bit synchronous RAM port,
// sequencing multi-byte little-endian accesses one byte per cycle.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   STATE_IDLE  | no transfer; accepts MEM (priority) or IF request
//   STATE_READ  | cnt < len: issue address base+cnt; cnt >= 1: collect lane cnt-1
//   STATE_WRITE | drive byte cnt of store data to base+cnt
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_read,
    input  logic [31:0]           if_addr,
    output logic                  if_busy,
    output logic                  if_ready,
    output logic [31:0]           if_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [2:0]            mem_length,
    input  logic                  mem_signed,
    output logic                  mem_busy,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din,
    output logic                  ram_wr
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic        signed_q, signed_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic [31:0]           addr_full;
    logic [31:0]           lane_buf;
    logic [31:0]           ext_word;
    logic [7:0]            wbyte;
    logic [RAM_ADDR_W-1:0] ram_a_c;
    logic [7:0]            ram_dout_c;
    logic                  ram_wr_c;
    logic                  unused_addr_hi;

    // Address arithmetic is 32-bit; the RAM only sees the low bits, so it wraps.
    assign addr_full      = base_q + 32'(cnt_q);
    assign unused_addr_hi = ^addr_full[31:RAM_ADDR_W];

    mem_ext u_ext (
        .raw       (lane_buf),
        .length    (len_q),
        .is_signed (signed_q),
        .ext       (ext_word)
    );

    always_comb begin
        lane_buf = buf_q;
        case (cnt_q)
            3'd1:    lane_buf[7:0]   = ram_din;
            3'd2:    lane_buf[15:8]  = ram_din;
            3'd3:    lane_buf[23:16] = ram_din;
            3'd4:    lane_buf[31:24] = ram_din;
            default: lane_buf = buf_q;
        endcase

        case (cnt_q[1:0])
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        signed_d    = signed_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_a_c     = '0;
        ram_dout_c  = '0;
        ram_wr_c    = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                if (mem_read || mem_write) begin
                    state_d  = mem_read ? STATE_READ : STATE_WRITE;
                    owner_d  = OWNER_MEM;
                    cnt_d    = 3'd0;
                    len_d    = norm_len(mem_length);
                    signed_d = mem_signed;
                    base_d   = mem_addr;
                    wdata_d  = mem_wdata;
                    buf_d    = '0;
                end else if (if_read) begin
                    state_d  = STATE_READ;
                    owner_d  = OWNER_IF;
                    cnt_d    = 3'd0;
                    len_d    = LEN_WORD;
                    signed_d = 1'b0;
                    base_d   = if_addr;
                    buf_d    = '0;
                end
            end

            STATE_READ: begin
                if (cnt_q != len_q) begin
                    ram_a_c = addr_full[RAM_ADDR_W-1:0];
                end
                buf_d = lane_buf;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == len_q) begin
                    state_d = STATE_IDLE;
                    cnt_d   = 3'd0;
                    if (owner_q == OWNER_MEM) begin
                        mem_ready_d = 1'b1;
                        mem_rdata_d = ext_word;
                    end else begin
                        if_ready_d = 1'b1;
                        if_data_d  = ext_word;
                    end
                end
            end

            STATE_WRITE: begin
                ram_wr_c   = 1'b1;
                ram_a_c    = addr_full[RAM_ADDR_W-1:0];
                ram_dout_c = wbyte;
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q == len_q - 3'd1) begin
                    state_d = STATE_IDLE;
                    cnt_d   = 3'd0;
                end
            end

            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= STATE_IDLE;
            owner_q     <= OWNER_IF;
            cnt_q       <= 3'd0;
            len_q       <= LEN_WORD;
            signed_q    <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            signed_q    <= signed_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // RAM pins are forced quiet during the reset cycle itself, even mid-transfer.
    assign ram_a     = reset ? '0 : ram_a_c;
    assign ram_dout  = reset ? '0 : ram_dout_c;
    assign ram_wr    = ram_wr_c & ~reset;

    assign mem_busy  = reset | (state_q != STATE_IDLE);
    assign if_busy   = mem_busy | mem_read | mem_write;
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;

endmodule
